// File: rtl/holy_axi_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : holy_axi_arbiter_if
//  Brief    : AXI4 channel bundle shared by the caches and the external port.
//  Revision : 1.0 - initial release
// ============================================================================
interface holy_axi_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [3:0]            awid;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [3:0]            bid;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arid;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [3:0]            rid;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/holy_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : holy_axi_arbiter
//  Brief    : Round-robin I/D-cache arbiter onto one AXI port, one whole
//             transaction per grant, channels routed combinationally.
//  Revision : 1.0 - initial release
// ============================================================================
module holy_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire                  clk,
    input  wire                  rst_n,
    holy_axi_arbiter_if.slave    s_icache,
    holy_axi_arbiter_if.slave    s_dcache,
    holy_axi_arbiter_if.master   m_axi,
    output logic                 grant,
    output logic                 busy,
    output logic                 protocol_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_grant;
    logic        r_last_gnt;
    logic [7:0]  r_beat_cnt;
    logic        r_protocol_err;

    logic w_req_i, w_req_d, w_win, w_win_aw;
    logic w_aw, w_w, w_b, w_ar, w_r;
    logic w_sel_i, w_sel_d;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign w_req_i  = s_icache.awvalid | s_icache.arvalid;
    assign w_req_d  = s_dcache.awvalid | s_dcache.arvalid;
    // On a tie the requester that did not win last time goes next.
    assign w_win    = (w_req_i & w_req_d) ? ~r_last_gnt : w_req_d;
    assign w_win_aw = w_win ? s_dcache.awvalid : s_icache.awvalid;

    assign w_aw    = (r_state == S_WR_ADDR);
    assign w_w     = (r_state == S_WR_DATA);
    assign w_b     = (r_state == S_WR_RESP);
    assign w_ar    = (r_state == S_RD_ADDR);
    assign w_r     = (r_state == S_RD_DATA);
    assign w_sel_i = ~r_grant;
    assign w_sel_d = r_grant;

    assign w_aw_hs = m_axi.awvalid & m_axi.awready;
    assign w_w_hs  = m_axi.wvalid  & m_axi.wready;
    assign w_b_hs  = m_axi.bvalid  & m_axi.bready;
    assign w_ar_hs = m_axi.arvalid & m_axi.arready;
    assign w_r_hs  = m_axi.rvalid  & m_axi.rready;

    // External port: only the granted cache, only on the channel of the state.
    assign m_axi.awvalid = w_aw & (r_grant ? s_dcache.awvalid : s_icache.awvalid);
    assign m_axi.awaddr  = w_aw ? (r_grant ? s_dcache.awaddr  : s_icache.awaddr)  : {ADDR_W{1'b0}};
    assign m_axi.awlen   = w_aw ? (r_grant ? s_dcache.awlen   : s_icache.awlen)   : 8'd0;
    assign m_axi.awsize  = w_aw ? (r_grant ? s_dcache.awsize  : s_icache.awsize)  : 3'd0;
    assign m_axi.awburst = w_aw ? (r_grant ? s_dcache.awburst : s_icache.awburst) : 2'd0;
    assign m_axi.awid    = w_aw ? (r_grant ? s_dcache.awid    : s_icache.awid)    : 4'd0;

    assign m_axi.wvalid  = w_w & (r_grant ? s_dcache.wvalid : s_icache.wvalid);
    assign m_axi.wdata   = w_w ? (r_grant ? s_dcache.wdata : s_icache.wdata) : {DATA_W{1'b0}};
    assign m_axi.wstrb   = w_w ? (r_grant ? s_dcache.wstrb : s_icache.wstrb) : {(DATA_W/8){1'b0}};
    assign m_axi.wlast   = w_w & (r_grant ? s_dcache.wlast : s_icache.wlast);

    assign m_axi.bready  = w_b & (r_grant ? s_dcache.bready : s_icache.bready);

    assign m_axi.arvalid = w_ar & (r_grant ? s_dcache.arvalid : s_icache.arvalid);
    assign m_axi.araddr  = w_ar ? (r_grant ? s_dcache.araddr  : s_icache.araddr)  : {ADDR_W{1'b0}};
    assign m_axi.arlen   = w_ar ? (r_grant ? s_dcache.arlen   : s_icache.arlen)   : 8'd0;
    assign m_axi.arsize  = w_ar ? (r_grant ? s_dcache.arsize  : s_icache.arsize)  : 3'd0;
    assign m_axi.arburst = w_ar ? (r_grant ? s_dcache.arburst : s_icache.arburst) : 2'd0;
    assign m_axi.arid    = w_ar ? (r_grant ? s_dcache.arid    : s_icache.arid)    : 4'd0;

    assign m_axi.rready  = w_r & (r_grant ? s_dcache.rready : s_icache.rready);

    assign s_icache.awready = w_aw & w_sel_i & m_axi.awready;
    assign s_icache.wready  = w_w  & w_sel_i & m_axi.wready;
    assign s_icache.bvalid  = w_b  & w_sel_i & m_axi.bvalid;
    assign s_icache.bresp   = (w_b & w_sel_i) ? m_axi.bresp : 2'd0;
    assign s_icache.bid     = (w_b & w_sel_i) ? m_axi.bid   : 4'd0;
    assign s_icache.arready = w_ar & w_sel_i & m_axi.arready;
    assign s_icache.rvalid  = w_r  & w_sel_i & m_axi.rvalid;
    assign s_icache.rdata   = (w_r & w_sel_i) ? m_axi.rdata : {DATA_W{1'b0}};
    assign s_icache.rresp   = (w_r & w_sel_i) ? m_axi.rresp : 2'd0;
    assign s_icache.rlast   = w_r  & w_sel_i & m_axi.rlast;
    assign s_icache.rid     = (w_r & w_sel_i) ? m_axi.rid   : 4'd0;

    assign s_dcache.awready = w_aw & w_sel_d & m_axi.awready;
    assign s_dcache.wready  = w_w  & w_sel_d & m_axi.wready;
    assign s_dcache.bvalid  = w_b  & w_sel_d & m_axi.bvalid;
    assign s_dcache.bresp   = (w_b & w_sel_d) ? m_axi.bresp : 2'd0;
    assign s_dcache.bid     = (w_b & w_sel_d) ? m_axi.bid   : 4'd0;
    assign s_dcache.arready = w_ar & w_sel_d & m_axi.arready;
    assign s_dcache.rvalid  = w_r  & w_sel_d & m_axi.rvalid;
    assign s_dcache.rdata   = (w_r & w_sel_d) ? m_axi.rdata : {DATA_W{1'b0}};
    assign s_dcache.rresp   = (w_r & w_sel_d) ? m_axi.rresp : 2'd0;
    assign s_dcache.rlast   = w_r  & w_sel_d & m_axi.rlast;
    assign s_dcache.rid     = (w_r & w_sel_d) ? m_axi.rid   : 4'd0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_i | w_req_d) begin
                    w_state_nxt = w_win_aw ? S_WR_ADDR : S_RD_ADDR;
                end
            end
            S_WR_ADDR: if (w_aw_hs)                 w_state_nxt = S_WR_DATA;
            S_WR_DATA: if (w_w_hs & m_axi.wlast)    w_state_nxt = S_WR_RESP;
            S_WR_RESP: if (w_b_hs)                  w_state_nxt = S_IDLE;
            S_RD_ADDR: if (w_ar_hs)                 w_state_nxt = S_RD_DATA;
            S_RD_DATA: if (w_r_hs & m_axi.rlast)    w_state_nxt = S_IDLE;
            default:                                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_grant        <= 1'b0;
            r_last_gnt     <= 1'b1;
            r_beat_cnt     <= 8'd0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && (w_req_i | w_req_d)) begin
                r_grant    <= w_win;
                r_last_gnt <= w_win;
            end
            if (w_aw_hs) begin
                r_beat_cnt <= m_axi.awlen;
            end else if (w_w_hs && (r_beat_cnt != 8'd0)) begin
                r_beat_cnt <= r_beat_cnt - 8'd1;
            end
            // wlast must coincide exactly with the beat counter reaching zero.
            if (w_w_hs && (m_axi.wlast != (r_beat_cnt == 8'd0))) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign grant        = r_grant;
    assign busy         = (r_state != S_IDLE);
    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_holy_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_holy_axi_arbiter
//  Brief    : Self-checking bench: two cache models and a memory model around
//             the arbiter, compared every cycle against a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_holy_axi_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    holy_axi_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ic ();
    holy_axi_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dc ();
    holy_axi_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();
    logic grant, busy, protocol_err;

    holy_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_icache     (ic),
        .s_dcache     (dc),
        .m_axi        (mem),
        .grant        (grant),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    // Cache-side drive values, index 0 = I-cache, 1 = D-cache
    logic [1:0]  d_awvalid, d_arvalid, d_wvalid, d_wlast, d_bready, d_rready;
    logic [31:0] d_awaddr [2];
    logic [31:0] d_araddr [2];
    logic [31:0] d_wdata  [2];
    logic [7:0]  d_awlen  [2];
    logic [7:0]  d_arlen  [2];
    logic [3:0]  d_wstrb  [2];
    // Memory-side drive values
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_rlast;
    logic [1:0]  s_bresp, s_rresp;
    logic [3:0]  s_bid, s_rid;
    logic [31:0] s_rdata;

    assign ic.awvalid = d_awvalid[0]; assign dc.awvalid = d_awvalid[1];
    assign ic.awaddr  = d_awaddr[0];  assign dc.awaddr  = d_awaddr[1];
    assign ic.awlen   = d_awlen[0];   assign dc.awlen   = d_awlen[1];
    assign ic.awsize  = 3'd2;         assign dc.awsize  = 3'd2;
    assign ic.awburst = 2'd1;         assign dc.awburst = 2'd1;
    assign ic.awid    = 4'd0;         assign dc.awid    = 4'd1;
    assign ic.wvalid  = d_wvalid[0];  assign dc.wvalid  = d_wvalid[1];
    assign ic.wdata   = d_wdata[0];   assign dc.wdata   = d_wdata[1];
    assign ic.wstrb   = d_wstrb[0];   assign dc.wstrb   = d_wstrb[1];
    assign ic.wlast   = d_wlast[0];   assign dc.wlast   = d_wlast[1];
    assign ic.bready  = d_bready[0];  assign dc.bready  = d_bready[1];
    assign ic.arvalid = d_arvalid[0]; assign dc.arvalid = d_arvalid[1];
    assign ic.araddr  = d_araddr[0];  assign dc.araddr  = d_araddr[1];
    assign ic.arlen   = d_arlen[0];   assign dc.arlen   = d_arlen[1];
    assign ic.arsize  = 3'd2;         assign dc.arsize  = 3'd2;
    assign ic.arburst = 2'd1;         assign dc.arburst = 2'd1;
    assign ic.arid    = 4'd0;         assign dc.arid    = 4'd1;
    assign ic.rready  = d_rready[0];  assign dc.rready  = d_rready[1];

    assign mem.awready = s_awready;
    assign mem.wready  = s_wready;
    assign mem.bvalid  = s_bvalid;
    assign mem.bresp   = s_bresp;
    assign mem.bid     = s_bid;
    assign mem.arready = s_arready;
    assign mem.rvalid  = s_rvalid;
    assign mem.rdata   = s_rdata;
    assign mem.rresp   = s_rresp;
    assign mem.rlast   = s_rlast;
    assign mem.rid     = s_rid;

    // Transaction-level model of who owns the port and which phase it is in.
    localparam int P_IDLE = 0, P_AW = 1, P_W = 2, P_B = 3, P_AR = 4, P_R = 5;
    bit          act, o, last_b, wv, rv, bp, err_exp, full_speed;
    int          ph, w_idx, r_idx, cycle, t_grant, t_done;
    bit          aw_pend [2];
    bit          ar_pend [2];
    logic [31:0] aw_addr [2];
    logic [31:0] ar_addr [2];
    int          aw_len  [2];
    int          ar_len  [2];
    int          w_last_at [2];
    logic [1:0]  b_resp;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit rnd();
        return ($urandom_range(3) != 0);
    endfunction

    function automatic logic [31:0] wdat(input bit k, input int i);
        return {7'd0, k, 8'(i), aw_addr[k][15:0]};
    endfunction

    function automatic logic [31:0] rdat(input bit k, input int i);
        return ar_addr[k] ^ {8'(i), 8'(i), 15'd0, k};
    endfunction

    function automatic logic [4:0] exp_out(input bit k);
        if (!(act && o == k)) return 5'd0;
        return {ph == P_AW && s_awready, ph == P_W && s_wready, ph == P_B && bp,
                ph == P_AR && s_arready, ph == P_R && rv};
    endfunction

    task automatic clear_model();
        act = 0; o = 0; ph = P_IDLE; last_b = 1; wv = 0; rv = 0; bp = 0; err_exp = 0;
        w_idx = 0; r_idx = 0; b_resp = 2'd0;
        for (int k = 0; k < 2; k++) begin
            aw_pend[k] = 0; ar_pend[k] = 0; aw_addr[k] = 32'd0; ar_addr[k] = 32'd0;
            aw_len[k] = 0; ar_len[k] = 0; w_last_at[k] = 0;
        end
    endtask

    task automatic drive();
        if (act && ph == P_W && !wv) wv = full_speed || rnd();
        if (act && ph == P_R && !rv) rv = full_speed || rnd();
        for (int k = 0; k < 2; k++) begin
            d_awvalid[k] = aw_pend[k]; d_awaddr[k] = aw_addr[k]; d_awlen[k] = 8'(aw_len[k]);
            d_arvalid[k] = ar_pend[k]; d_araddr[k] = ar_addr[k]; d_arlen[k] = 8'(ar_len[k]);
            d_bready[k]  = full_speed || rnd();
            d_rready[k]  = full_speed || rnd();
            d_wvalid[k]  = 1'b0; d_wdata[k] = 32'd0; d_wstrb[k] = 4'd0; d_wlast[k] = 1'b0;
        end
        if (act && ph == P_W) begin
            d_wvalid[o] = wv;
            d_wdata[o]  = wdat(o, w_idx);
            d_wstrb[o]  = 4'(w_idx);
            d_wlast[o]  = (w_idx == w_last_at[o]);
        end
        s_awready = full_speed || rnd();
        s_wready  = full_speed || rnd();
        s_arready = full_speed || rnd();
        s_bvalid  = act && ph == P_B && bp;
        s_bresp   = b_resp;
        s_bid     = 4'(o);
        s_rvalid  = act && ph == P_R && rv;
        s_rdata   = rdat(o, r_idx);
        s_rresp   = 2'(r_idx);
        s_rlast   = (r_idx == ar_len[o]);
        s_rid     = 4'(o);
    endtask

    task automatic sample();
        bit lastb, win;
        chk("busy", busy, act);
        if (act) chk("grant", grant, o);
        chk("protocol_err", protocol_err, err_exp);
        chk("m_handshake", {mem.awvalid, mem.wvalid, mem.bready, mem.arvalid, mem.rready},
            {act && ph == P_AW, act && ph == P_W && wv, act && ph == P_B && d_bready[o],
             act && ph == P_AR, act && ph == P_R && d_rready[o]});
        chk("icache_out", {ic.awready, ic.wready, ic.bvalid, ic.arready, ic.rvalid}, exp_out(0));
        chk("dcache_out", {dc.awready, dc.wready, dc.bvalid, dc.arready, dc.rvalid}, exp_out(1));
        if (act && ph == P_AW)
            chk("aw_fields", {mem.awaddr, mem.awlen, mem.awid}, {aw_addr[o], 8'(aw_len[o]), 4'(o)});
        if (act && ph == P_AR)
            chk("ar_fields", {mem.araddr, mem.arlen, mem.arid}, {ar_addr[o], 8'(ar_len[o]), 4'(o)});
        if (act && ph == P_W && wv)
            chk("w_fields", {mem.wdata, mem.wstrb, mem.wlast},
                {wdat(o, w_idx), 4'(w_idx), w_idx == w_last_at[o]});
        if (act && ph == P_B && bp)
            chk("b_fields", o ? {dc.bresp, dc.bid} : {ic.bresp, ic.bid}, {b_resp, 4'(o)});
        if (act && ph == P_R && rv)
            chk("r_fields", o ? {dc.rdata, dc.rresp, dc.rlast} : {ic.rdata, ic.rresp, ic.rlast},
                {rdat(o, r_idx), 2'(r_idx), r_idx == ar_len[o]});

        if (!act) begin
            if (aw_pend[0] || ar_pend[0] || aw_pend[1] || ar_pend[1]) begin
                if ((aw_pend[0] || ar_pend[0]) && (aw_pend[1] || ar_pend[1])) win = !last_b;
                else win = aw_pend[1] || ar_pend[1];
                last_b = win; o = win; act = 1; t_grant = cycle;
                ph = aw_pend[win] ? P_AW : P_AR;
            end
        end else begin
            case (ph)
                P_AW: if (s_awready) begin aw_pend[o] = 0; ph = P_W; w_idx = 0; wv = 0; end
                P_W: if (wv && s_wready) begin
                    lastb = (w_idx == w_last_at[o]);
                    if ((lastb && w_idx != aw_len[o]) || (!lastb && w_idx >= aw_len[o])) err_exp = 1;
                    wv = 0;
                    if (lastb) begin ph = P_B; bp = 1; b_resp = 2'($urandom_range(3)); end
                    else w_idx++;
                end
                P_B: if (bp && d_bready[o]) begin bp = 0; act = 0; ph = P_IDLE; t_done = cycle; end
                P_AR: if (s_arready) begin ar_pend[o] = 0; ph = P_R; r_idx = 0; rv = 0; end
                P_R: if (rv && d_rready[o]) begin
                    rv = 0;
                    if (r_idx == ar_len[o]) begin act = 0; ph = P_IDLE; t_done = cycle; end
                    else r_idx++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((act || aw_pend[0] || ar_pend[0] || aw_pend[1] || ar_pend[1]) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_within_budget", n < budget, 1'b1);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic req_rd(input bit k, input logic [31:0] a, input int len);
        ar_pend[k] = 1; ar_addr[k] = a; ar_len[k] = len;
    endtask

    task automatic req_wr(input bit k, input logic [31:0] a, input int len, input int last_at);
        aw_pend[k] = 1; aw_addr[k] = a; aw_len[k] = len; w_last_at[k] = last_at;
    endtask

    initial begin
        int len;
        cycle = 0; t_grant = 0; t_done = 0; full_speed = 0;
        do_reset();
        chk("reset_grant", grant, 1'b0);
        chk("reset_busy", busy, 1'b0);
        tick();

        // Single I-cache read, memory always ready
        full_speed = 1;
        req_rd(0, 32'h0000_0200, 127);
        wait_idle(400);
        chk("read_back_to_back", t_done - t_grant, 129);
        full_speed = 0;

        // Simultaneous reads right after reset: I-cache first
        do_reset();
        req_rd(0, 32'h0000_1000, 7);
        req_rd(1, 32'h8000_2000, 5);
        wait_idle(400);

        // Round-robin: D alone, then a tie must go to I
        for (int i = 0; i < 4; i++) begin
            req_rd(1, 32'h8000_3000 + 32'(i * 64), int'($urandom_range(0, 7)));
            wait_idle(400);
            req_rd(0, 32'h0000_3000 + 32'(i * 64), int'($urandom_range(0, 7)));
            req_rd(1, 32'h8000_4000 + 32'(i * 64), int'($urandom_range(0, 7)));
            wait_idle(400);
        end

        // Writeback then refill, with an I-cache miss raised mid-write
        req_wr(1, 32'h8000_5000, 127, 127);
        req_rd(1, 32'h8000_6000, 15);
        repeat (20) tick();
        req_rd(0, 32'h0000_7000, 3);
        wait_idle(1500);
        chk("no_protocol_err", protocol_err, 1'b0);

        // Early wlast: sticky error, transaction still closes
        req_wr(1, 32'h8000_8000, 127, 100);
        wait_idle(1500);
        chk("protocol_err_set", protocol_err, 1'b1);
        req_rd(0, 32'h0000_9000, 3);
        wait_idle(400);
        chk("protocol_err_sticky", protocol_err, 1'b1);

        // Asynchronous reset in the middle of a read burst
        req_rd(0, 32'h0000_a000, 127);
        for (int n = 0; n < 1000 && !(act && ph == P_R && r_idx == 50); n++) tick();
        chk("reached_beat_50", act && ph == P_R && r_idx == 50, 1'b1);
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_grant", grant, 1'b0);
        chk("arst_perr", protocol_err, 1'b0);
        chk("arst_m_out", {mem.awvalid, mem.wvalid, mem.bready, mem.arvalid, mem.rready}, 5'd0);
        chk("arst_s_out", {ic.awready, ic.wready, ic.bvalid, ic.arready, ic.rvalid,
                           dc.awready, dc.wready, dc.bvalid, dc.arready, dc.rvalid}, 10'd0);
        do_reset();
        req_rd(1, 32'h8000_b000, 3);
        wait_idle(400);

        // Random mixed traffic from both caches
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!aw_pend[k] && !ar_pend[k] && !(act && o == bit'(k)) && rnd()) begin
                    len = int'($urandom_range(0, 15));
                    if ($urandom_range(1)) req_rd(bit'(k), $urandom, len);
                    else req_wr(bit'(k), $urandom, len, ($urandom_range(7) == 0) ? len / 2 : len);
                    if ($urandom_range(3) == 0) req_rd(bit'(k), $urandom, int'($urandom_range(0, 7)));
                end
            end
            repeat ($urandom_range(1, 20)) tick();
        end
        wait_idle(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
